// File: rtl/obi_arbiter_2to1.sv
// Two-host to one-device OBI arbiter: round-robin address-phase arbitration with
// lock-until-grant, and an ID FIFO that routes in-order responses back to their host.
module obi_arbiter_2to1 #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 39,
    parameter int BE_BITS   = DATA_W / 8,
    parameter int MAX_OUTST = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               h0_req_i,
    input  logic               h0_we_i,
    input  logic [BE_BITS-1:0] h0_be_i,
    input  logic [ADDR_W-1:0]  h0_addr_i,
    input  logic [DATA_W-1:0]  h0_wdata_i,
    output logic               h0_gnt_o,
    output logic               h0_rvalid_o,
    output logic [DATA_W-1:0]  h0_rdata_o,
    input  logic               h1_req_i,
    input  logic               h1_we_i,
    input  logic [BE_BITS-1:0] h1_be_i,
    input  logic [ADDR_W-1:0]  h1_addr_i,
    input  logic [DATA_W-1:0]  h1_wdata_i,
    output logic               h1_gnt_o,
    output logic               h1_rvalid_o,
    output logic [DATA_W-1:0]  h1_rdata_o,
    output logic               dev_req_o,
    output logic               dev_we_o,
    output logic [BE_BITS-1:0] dev_be_o,
    output logic [ADDR_W-1:0]  dev_addr_o,
    output logic [DATA_W-1:0]  dev_wdata_o,
    input  logic               dev_gnt_i,
    input  logic               dev_rvalid_i,
    input  logic [DATA_W-1:0]  dev_rdata_i,
    output logic               err_o
);

    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

    logic             lock_r;
    logic             lock_id_r;
    logic             prio_r;
    logic             err_r;
    logic             id_mem_r [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic sel_s;
    logic sel_req_s;
    logic empty_s;
    logic full_s;
    logic push_s;
    logic pop_s;
    logic head_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Host selection: a locked phase is never re-arbitrated; ties go to prio_r.
    always_comb begin
        sel_s = 1'b0;
        if (lock_r) begin
            sel_s = lock_id_r;
        end else if (h0_req_i && h1_req_i) begin
            sel_s = prio_r;
        end else if (h1_req_i) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Address-phase mux, request qualification and grant steering.
    always_comb begin
        sel_req_s = sel_s ? h1_req_i : h0_req_i;
        empty_s   = (count_r == {CNT_W{1'b0}});
        full_s    = (count_r == CNT_FULL);
        head_s    = id_mem_r[rd_ptr_r];
        pop_s     = dev_rvalid_i && !empty_s;
        // A pop in this cycle frees a slot, so a full FIFO may still accept a grant.
        dev_req_o = sel_req_s && (!full_s || pop_s) && !rst_i;
        push_s    = dev_req_o && dev_gnt_i;
        h0_gnt_o  = push_s && !sel_s;
        h1_gnt_o  = push_s && sel_s;
        if (sel_s) begin
            dev_we_o    = h1_we_i;
            dev_be_o    = h1_be_i;
            dev_addr_o  = h1_addr_i;
            dev_wdata_o = h1_wdata_i;
        end else begin
            dev_we_o    = h0_we_i;
            dev_be_o    = h0_be_i;
            dev_addr_o  = h0_addr_i;
            dev_wdata_o = h0_wdata_i;
        end
    end

    // Response routing from the FIFO head; the protocol error flag is hidden during reset.
    always_comb begin
        h0_rvalid_o = pop_s && !head_s && !rst_i;
        h1_rvalid_o = pop_s && head_s && !rst_i;
        h0_rdata_o  = dev_rdata_i;
        h1_rdata_o  = dev_rdata_i;
        err_o       = err_r && !rst_i;
    end

    // Lock, round-robin priority and sticky error state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_r    <= 1'b0;
            lock_id_r <= 1'b0;
            prio_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            if (push_s) begin
                lock_r <= 1'b0;
                prio_r <= ~sel_s;
            end else if (dev_req_o) begin
                lock_r    <= 1'b1;
                lock_id_r <= sel_s;
            end
            if (dev_rvalid_i && empty_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // ID FIFO: pointers and occupancy; push and pop together keep the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // ID FIFO storage: the host index of each granted transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                id_mem_r[i] <= 1'b0;
            end
        end else if (push_s) begin
            id_mem_r[wr_ptr_r] <= sel_s;
        end
    end

endmodule

// File: tb/tb_obi_arbiter_2to1.sv
// Scoreboard bench for obi_arbiter_2to1: a transaction-level model predicts grants,
// responses and per-cycle address-phase outputs; a negedge monitor compares.
module tb_obi_arbiter_2to1;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 39;
    localparam int BE_BITS = 8;
    localparam int MAX = 2;

    typedef struct {
        bit                host;
        logic [ADDR_W-1:0] addr;
    } gnt_t;

    typedef struct {
        bit                host;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               h0_req_i = 1'b0, h1_req_i = 1'b0;
    logic               h0_we_i = 1'b0, h1_we_i = 1'b0;
    logic [BE_BITS-1:0] h0_be_i = '0, h1_be_i = '0;
    logic [ADDR_W-1:0]  h0_addr_i = '0, h1_addr_i = '0;
    logic [DATA_W-1:0]  h0_wdata_i = '0, h1_wdata_i = '0;
    logic               h0_gnt_o, h1_gnt_o, h0_rvalid_o, h1_rvalid_o;
    logic [DATA_W-1:0]  h0_rdata_o, h1_rdata_o;
    logic               dev_req_o, dev_we_o;
    logic [BE_BITS-1:0] dev_be_o;
    logic [ADDR_W-1:0]  dev_addr_o;
    logic [DATA_W-1:0]  dev_wdata_o;
    logic               dev_gnt_i = 1'b0, dev_rvalid_i = 1'b0;
    logic [DATA_W-1:0]  dev_rdata_i = '0;
    logic               err_o;

    obi_arbiter_2to1 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BE_BITS(BE_BITS), .MAX_OUTST(MAX)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .h0_req_i(h0_req_i), .h0_we_i(h0_we_i), .h0_be_i(h0_be_i), .h0_addr_i(h0_addr_i),
        .h0_wdata_i(h0_wdata_i), .h0_gnt_o(h0_gnt_o), .h0_rvalid_o(h0_rvalid_o), .h0_rdata_o(h0_rdata_o),
        .h1_req_i(h1_req_i), .h1_we_i(h1_we_i), .h1_be_i(h1_be_i), .h1_addr_i(h1_addr_i),
        .h1_wdata_i(h1_wdata_i), .h1_gnt_o(h1_gnt_o), .h1_rvalid_o(h1_rvalid_o), .h1_rdata_o(h1_rdata_o),
        .dev_req_o(dev_req_o), .dev_we_o(dev_we_o), .dev_be_o(dev_be_o), .dev_addr_o(dev_addr_o),
        .dev_wdata_o(dev_wdata_o), .dev_gnt_i(dev_gnt_i), .dev_rvalid_i(dev_rvalid_i),
        .dev_rdata_i(dev_rdata_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Host-side pending transactions (held until granted).
    bit                h_req [2];
    logic              h_we [2];
    logic [BE_BITS-1:0] h_be [2];
    logic [ADDR_W-1:0] h_addr [2];
    logic [DATA_W-1:0] h_wdata [2];

    // Reference model: outstanding host IDs in grant order, plus arbitration history.
    bit   out_q [$];
    int   lock_m = -1;
    int   last_m = 1;
    bit   err_m = 1'b0;

    // Expectations for the monitor.
    gnt_t exp_gnt_q [$];
    rsp_t exp_rsp_q [$];
    bit                 exp_req = 1'b0;
    bit                 exp_err = 1'b0;
    logic               exp_we = 1'b0;
    logic [BE_BITS-1:0] exp_be = '0;
    logic [ADDR_W-1:0]  exp_addr = '0;
    logic [DATA_W-1:0]  exp_wdata = '0;

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    gnt_t g_pop;
    rsp_t r_pop;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_req(input int h, input logic we, input logic [ADDR_W-1:0] a);
        h_req[h]   = 1'b1;
        h_we[h]    = we;
        h_addr[h]  = a;
        h_be[h]    = BE_BITS'($urandom);
        h_wdata[h] = {$urandom, $urandom};
    endtask

    task automatic step(input bit rst, input bit g, input bit rv, input logic [DATA_W-1:0] rd);
        int w;
        int qn;
        bit pop_m;
        bit req_m;
        @(posedge clk);
        #1;
        rst_i = rst;
        h0_req_i = h_req[0]; h0_we_i = h_we[0]; h0_be_i = h_be[0];
        h0_addr_i = h_addr[0]; h0_wdata_i = h_wdata[0];
        h1_req_i = h_req[1]; h1_we_i = h_we[1]; h1_be_i = h_be[1];
        h1_addr_i = h_addr[1]; h1_wdata_i = h_wdata[1];
        dev_gnt_i = g; dev_rvalid_i = rv; dev_rdata_i = rd;
        qn = out_q.size();
        if (lock_m >= 0) w = lock_m;
        else if (h_req[0] && h_req[1]) w = 1 - last_m;
        else if (h_req[1]) w = 1;
        else w = 0;
        pop_m = rv && !rst && (qn > 0);
        req_m = !rst && h_req[w] && ((qn < MAX) || pop_m);
        exp_req = req_m;
        exp_we = h_we[w]; exp_be = h_be[w]; exp_addr = h_addr[w]; exp_wdata = h_wdata[w];
        exp_err = err_m && !rst;
        if (pop_m) exp_rsp_q.push_back('{out_q.pop_front(), rd});
        if (req_m && g) begin
            exp_gnt_q.push_back('{w[0], h_addr[w]});
            out_q.push_back(w[0]);
            last_m = w;
            lock_m = -1;
            h_req[w] = 1'b0;
        end else if (req_m) begin
            lock_m = w;
        end
        if (rst) begin
            out_q.delete();
            lock_m = -1;
            last_m = 1;
            err_m = 1'b0;
        end else if (rv && qn == 0) begin
            err_m = 1'b1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && out_q.size() > 0; k++) step(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
    endtask

    // Monitor: per-cycle address phase, plus grants/responses popped from the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("dev_req", 64'(dev_req_o), 64'(exp_req));
            chk("err", 64'(err_o), 64'(exp_err));
            chk("dev_addr", 64'(dev_addr_o), 64'(exp_addr));
            chk("dev_we", 64'(dev_we_o), 64'(exp_we));
            chk("dev_be", 64'(dev_be_o), 64'(exp_be));
            chk("dev_wdata", dev_wdata_o, exp_wdata);
            if (h0_gnt_o || h1_gnt_o) begin
                if (exp_gnt_q.size() == 0) begin
                    chk("gnt_unexpected", 64'({h1_gnt_o, h0_gnt_o}), 64'(0));
                end else begin
                    g_pop = exp_gnt_q.pop_front();
                    chk("gnt_host", 64'({h1_gnt_o, h0_gnt_o}), g_pop.host ? 64'(2) : 64'(1));
                    chk("gnt_addr", 64'(dev_addr_o), 64'(g_pop.addr));
                end
            end
            if (h0_rvalid_o || h1_rvalid_o) begin
                if (exp_rsp_q.size() == 0) begin
                    chk("rvalid_unexpected", 64'({h1_rvalid_o, h0_rvalid_o}), 64'(0));
                end else begin
                    r_pop = exp_rsp_q.pop_front();
                    chk("rvalid_host", 64'({h1_rvalid_o, h0_rvalid_o}), r_pop.host ? 64'(2) : 64'(1));
                    chk("rdata", r_pop.host ? h1_rdata_o : h0_rdata_o, r_pop.data);
                end
            end
        end
    end

    initial begin
        for (int h = 0; h < 2; h++) begin
            h_req[h] = 1'b0; h_we[h] = 1'b0; h_be[h] = '0; h_addr[h] = '0; h_wdata[h] = '0;
        end
        step(1'b1, 1'b0, 1'b0, '0);
        mon_en = 1'b1;
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);

        // Single read
        set_req(0, 1'b0, 39'h100);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 64'hDEADBEEF);

        // Round-robin with both hosts always requesting
        for (int c = 0; c < 6; c++) begin
            for (int h = 0; h < 2; h++) if (!h_req[h]) set_req(h, 1'b0, ADDR_W'(32'h1000 + c * 16 + h));
            step(1'b0, 1'b1, out_q.size() > 0, {$urandom, $urandom});
        end
        h_req[0] = 1'b0; h_req[1] = 1'b0;
        drain();

        // Mixed ordering: h0 read, h1 write, responses later
        set_req(0, 1'b0, 39'h300);
        step(1'b0, 1'b1, 1'b0, '0);
        set_req(1, 1'b1, 39'h308);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 64'h1111);
        step(1'b0, 1'b0, 1'b1, 64'h2222);

        // Lock: h1 held ungranted while h0 arrives
        set_req(1, 1'b0, 39'h200);
        step(1'b0, 1'b0, 1'b0, '0);
        set_req(0, 1'b0, 39'h400);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        drain();

        // Full FIFO, then pop and grant in the same cycle
        for (int c = 0; c < 5; c++) begin
            if (!h_req[0]) set_req(0, 1'b0, ADDR_W'(32'h500 + c * 8));
            step(1'b0, 1'b1, c == 3, {$urandom, $urandom});
        end
        h_req[0] = 1'b0;
        drain();

        // Reset with transactions outstanding, then a late rvalid
        set_req(0, 1'b0, 39'h600);
        step(1'b0, 1'b1, 1'b0, '0);
        set_req(1, 1'b0, 39'h608);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 64'hBAD);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            bit r;
            for (int h = 0; h < 2; h++)
                if (!h_req[h] && $urandom_range(0, 2) == 0)
                    set_req(h, 1'($urandom_range(0, 1)), ADDR_W'({$urandom, $urandom}));
            r = ($urandom_range(0, 499) == 0);
            step(r, $urandom_range(0, 3) != 0, !r && out_q.size() > 0 && $urandom_range(0, 1) == 1,
                 {$urandom, $urandom});
        end
        for (int c = 0; c < 20; c++) step(1'b0, 1'b1, out_q.size() > 0, {$urandom, $urandom});
        step(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("gnt_queue_left", 64'(exp_gnt_q.size()), 64'(0));
        chk("rsp_queue_left", 64'(exp_rsp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
